// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// reset constants, hold-buffer entry layout and sequential-PC helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Next sequential PC: bit 31 (kernel mode) is sticky, the low 31 bits wrap.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    logic [30:0] lo;
    lo = pc[30:0] + 31'd4;
    return {pc[31], lo};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched {instr, pc} while ID is stalled.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clear_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o,
  output logic         valid_o
);

  fetch_entry_t entry_q;
  logic         valid_q;

  // Clear wins over load: a redirect must never leave a stale entry behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      entry_q <= entry_i;
      valid_q <= 1'b1;
    end
  end

  assign entry_o = entry_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding imem fetch FSM, hold buffer
// and IF/ID pipeline register.
//
// state | meaning
// IDLE  | nothing outstanding; may issue a fetch at PC
// WAIT  | one fetch in flight for address PC; response is delivered
// KILL  | one fetch in flight that was squashed by a redirect; drop its response
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] PC_next,
  input  logic        IFIDFlush,
  input  logic        trap,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PC_plus_4,
  output logic        IFID_valid
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [31:0]  ifid_pc4_q, ifid_pc4_d;
  logic         ifid_valid_q, ifid_valid_d;

  logic         redirect;
  logic         deliver;
  logic         issue;
  logic         hold_valid;
  logic         hold_load;
  logic         hold_clear;
  fetch_entry_t hold_entry;
  fetch_entry_t resp_entry;

  // Trap overrides a load-use stall; a plain flush waits for the stall to clear.
  assign redirect = trap | (IFIDFlush & ~stall);
  assign deliver  = (state_q == WAIT) & imem_rvalid & ~redirect;
  assign issue    = imem_req & imem_ready;

  assign resp_entry = '{instr: imem_rdata, pc: pc_q};
  assign hold_load  = deliver & stall;
  assign hold_clear = redirect | (~stall & hold_valid);

  fetch_hold_buf u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .entry_i (resp_entry),
    .entry_o (hold_entry),
    .valid_o (hold_valid)
  );

  // Request issue: from IDLE at PC, or back-to-back at seq(PC) as a response lands.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      IDLE: imem_req = ~redirect & ~stall & ~hold_valid;
      WAIT: begin
        imem_addr = seq_pc(pc_q);
        imem_req  = imem_rvalid & ~redirect & ~stall & ~hold_valid;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // Fetch FSM: at most one request outstanding; redirects squash it via KILL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (issue) state_q <= WAIT;
        WAIT: begin
          if (imem_rvalid)   state_q <= issue ? WAIT : IDLE;
          else if (redirect) state_q <= KILL;
        end
        KILL: if (imem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // PC advances only when its own fetch is delivered (to IF/ID or the hold buffer).
  always_comb begin
    pc_d = pc_q;
    if (redirect)     pc_d = PC_next;
    else if (deliver) pc_d = seq_pc(pc_q);
  end

  // IF/ID next value: redirect bubbles, stall holds, hold buffer drains before new data.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      if (hold_valid) begin
        ifid_instr_d = hold_entry.instr;
        ifid_pc4_d   = seq_pc(hold_entry.pc);
        ifid_valid_d = 1'b1;
      end else if (deliver) begin
        ifid_instr_d = imem_rdata;
        ifid_pc4_d   = seq_pc(pc_q);
        ifid_valid_d = 1'b1;
      end else begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign PC               = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PC_plus_4   = ifid_pc4_q;
  assign IFID_valid       = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an instruction-stream model (next expected PC in
// program order, memory word derived from address) checked every cycle,
// with directed scenarios followed by a randomized run.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] PC_next;
  logic        IFIDFlush, trap, stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_Instruction, IFID_PC_plus_4;
  logic        IFID_valid;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .PC               (PC),
    .PC_next          (PC_next),
    .IFIDFlush        (IFIDFlush),
    .trap             (trap),
    .stall            (stall),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PC_plus_4   (IFID_PC_plus_4),
    .IFID_valid       (IFID_valid)
  );

  int checks = 0;
  int errors = 0;

  // memory responder
  logic        mem_busy  = 1'b0;
  logic        mem_stale = 1'b0;
  logic [31:0] mem_addr  = 32'h0;
  int          mem_lat   = 0;
  int          next_lat  = 0;
  int          ready_pct = 100;

  // stream model
  logic [31:0] exp_stream = RST_PC;
  int          n_deliv    = 0;

  // last cycle's request observation
  logic        req_s, acc_s;
  logic [31:0] addr_s;

  function automatic logic [31:0] seqf(input logic [31:0] x);
    logic [31:0] y;
    y = x + 32'd4;
    return {x[31], y[30:0]};
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at posedge+1 with control inputs already set.
  task automatic tick();
    logic        redir, st, snap_v;
    logic [31:0] pcn, snap_i, snap_p4;
    redir   = trap | (IFIDFlush & ~stall);
    st      = stall;
    pcn     = PC_next;
    snap_v  = IFID_valid;
    snap_i  = IFID_Instruction;
    snap_p4 = IFID_PC_plus_4;
    imem_rvalid = mem_busy && (mem_lat <= 0);
    imem_rdata  = imem_rvalid ? memword(mem_addr) : 32'hDEAD_BEEF;
    imem_ready  = (mem_stale && mem_busy) ? 1'b0 : ($urandom_range(99) < ready_pct);
    #1;
    req_s  = imem_req;
    addr_s = imem_addr;
    acc_s  = imem_req & imem_ready;
    if (acc_s) check("single_outstanding", 32'(mem_busy & ~imem_rvalid), 32'h0);
    @(posedge clk);
    #1;
    if (imem_rvalid) begin
      mem_busy  = 1'b0;
      mem_stale = 1'b0;
    end else if (mem_busy) begin
      mem_lat--;
    end
    if (acc_s) begin
      mem_busy = 1'b1;
      mem_addr = addr_s;
      mem_lat  = next_lat;
    end
    if (redir) begin
      check("redir_valid", 32'(IFID_valid), 32'h0);
      check("redir_instr", IFID_Instruction, NOP);
      check("redir_pc", PC, pcn);
      exp_stream = pcn;
    end else if (st) begin
      check("stall_valid", 32'(IFID_valid), 32'(snap_v));
      check("stall_instr", IFID_Instruction, snap_i);
      check("stall_pc4", IFID_PC_plus_4, snap_p4);
    end else if (IFID_valid) begin
      check("stream_instr", IFID_Instruction, memword(exp_stream));
      check("stream_pc4", IFID_PC_plus_4, seqf(exp_stream));
      exp_stream = seqf(exp_stream);
      n_deliv++;
    end else begin
      check("bubble_instr", IFID_Instruction, NOP);
    end
  endtask

  task automatic drain();
    stall = 0; IFIDFlush = 0; trap = 0;
    ready_pct = 0;
    repeat (6) tick();
    ready_pct = 100;
  endtask

  initial begin
    logic [31:0] fa, snap_pc;
    logic        got;
    reset = 1'b1;
    PC_next = 32'h0; IFIDFlush = 0; trap = 0; stall = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", PC, RST_PC);
    check("rst_valid", 32'(IFID_valid), 32'h0);
    check("rst_instr", IFID_Instruction, NOP);
    check("rst_pc4", IFID_PC_plus_4, 32'h0);
    reset = 1'b0;

    // 1-cycle memory, no stall: back-to-back fetches from reset PC
    ready_pct = 100; next_lat = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("b2b_acc", 32'(acc_s), 32'h1);
      check("b2b_addr", addr_s, RST_PC + 32'(4 * i));
      if (i >= 1) check("b2b_valid", 32'(IFID_valid), 32'h1);
    end

    // redirect while waiting; response 3 cycles later must be dropped
    drain();
    next_lat = 3;
    tick();
    check("kill_first_acc", 32'(acc_s), 32'h1);
    IFIDFlush = 1; PC_next = 32'h0040_0100;
    tick();
    IFIDFlush = 0;
    next_lat = 0;
    repeat (3) begin
      tick();
      check("kill_noreq", 32'(req_s), 32'h0);
    end
    tick();
    check("kill_next_acc", 32'(acc_s), 32'h1);
    check("kill_next_addr", addr_s, 32'h0040_0100);

    // stall with a response landing: hold buffer then drain
    drain();
    tick();
    fa = addr_s;
    check("stall_first_acc", 32'(acc_s), 32'h1);
    stall = 1;
    repeat (3) begin
      tick();
      check("stall_noreq", 32'(req_s), 32'h0);
    end
    stall = 0;
    tick();
    check("hold_drain_noreq", 32'(req_s), 32'h0);
    check("hold_drain_valid", 32'(IFID_valid), 32'h1);
    check("hold_drain_instr", IFID_Instruction, memword(fa));
    tick();
    check("after_hold_acc", 32'(acc_s), 32'h1);
    check("after_hold_addr", addr_s, seqf(fa));

    // trap during stall clears the hold buffer
    drain();
    tick();
    stall = 1;
    tick();
    trap = 1; PC_next = 32'h8000_0004;
    tick();
    trap = 0; stall = 0;
    tick();
    check("trap_hold_cleared", 32'(IFID_valid), 32'h0);
    check("trap_next_acc", 32'(acc_s), 32'h1);
    check("trap_next_addr", addr_s, 32'h8000_0004);

    // flush together with stall is not a redirect
    drain();
    snap_pc = PC;
    stall = 1; IFIDFlush = 1; PC_next = 32'h1234_5678;
    tick();
    check("flush_stall_pc", PC, snap_pc);
    stall = 0; IFIDFlush = 0;

    // low-31-bit wrap, user and kernel mode
    trap = 1; PC_next = 32'h7FFF_FFFC;
    tick();
    trap = 0;
    repeat (4) tick();
    trap = 1; PC_next = 32'hFFFF_FFFC;
    tick();
    trap = 0;
    repeat (4) tick();

    // reset in the middle of a wait; late response must be ignored
    drain();
    trap = 1; PC_next = 32'h0000_1000;
    tick();
    trap = 0;
    next_lat = 4;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midrst_pc", PC, RST_PC);
    check("midrst_valid", 32'(IFID_valid), 32'h0);
    check("midrst_instr", IFID_Instruction, NOP);
    check("midrst_pc4", IFID_PC_plus_4, 32'h0);
    mem_stale  = mem_busy;
    exp_stream = RST_PC;
    @(posedge clk);
    #1;
    reset = 1'b0;
    next_lat = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (acc_s) begin
        got = 1'b1;
        check("midrst_req_addr", addr_s, RST_PC);
      end else begin
        check("midrst_no_deliver", 32'(IFID_valid), 32'h0);
      end
    end
    check("midrst_req_seen", 32'(got), 32'h1);

    // randomized traffic
    ready_pct = 70;
    n_deliv = 0;
    for (int i = 0; i < 800; i++) begin
      stall     = ($urandom_range(99) < 20);
      IFIDFlush = ($urandom_range(99) < 8);
      trap      = ($urandom_range(99) < 3);
      PC_next   = $urandom() & 32'hFFFF_FFFC;
      next_lat  = $urandom_range(3);
      tick();
    end
    check("liveness", 32'(n_deliv > 100), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
